// File: rtl/fp_operand_loader.sv
// Operand assembly front end for the single-precision adder: builds A and B
// from narrow MSB-first entries, then captures the adder result once.
module fp_operand_loader #(
  parameter int DATA_W = 8,
  parameter int WORD_W = 32,
  localparam int N     = WORD_W / DATA_W,
  localparam int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic              clear,
  input  logic [WORD_W-1:0] dataR,
  output logic [WORD_W-1:0] dataA,
  output logic [WORD_W-1:0] dataB,
  output logic [WORD_W-1:0] result,
  output logic              result_valid,
  output logic [1:0]        stage,
  output logic [IDX_W-1:0]  entry_idx
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EVAL   = 2'd2,
    DONE   = 2'd3
  } stateT;

  stateT state;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Entry k lands in the k-th slice counted from the MSB end.
  function automatic logic [WORD_W-1:0] insertEntry(
    input logic [WORD_W-1:0] word,
    input logic [IDX_W-1:0]  idx,
    input logic [DATA_W-1:0] value
  );
    logic [WORD_W-1:0] res;
    res = word;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        res[WORD_W-1-k*DATA_W -: DATA_W] = value;
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD_A;
      entry_idx    <= '0;
      dataA        <= '0;
      dataB        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (clear) begin
      state        <= LOAD_A;
      entry_idx    <= '0;
      dataA        <= '0;
      dataB        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (load) begin
            dataA <= insertEntry(dataA, entry_idx, data_in);
            if (entry_idx == LAST_IDX) begin
              entry_idx <= '0;
              state     <= LOAD_B;
            end else begin
              entry_idx <= entry_idx + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (load) begin
            dataB <= insertEntry(dataB, entry_idx, data_in);
            if (entry_idx == LAST_IDX) begin
              entry_idx <= '0;
              state     <= EVAL;
            end else begin
              entry_idx <= entry_idx + IDX_W'(1);
            end
          end
        end
        EVAL: begin
          result       <= dataR;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          // A load here starts a new operation and doubles as entry 0 of A.
          if (load) begin
            result_valid                <= 1'b0;
            state                       <= LOAD_A;
            dataA[WORD_W-1 -: DATA_W]   <= data_in;
            entry_idx                   <= IDX_W'(1);
          end
        end
        default: begin
          state     <= LOAD_A;
          entry_idx <= '0;
        end
      endcase
    end
  end

  assign stage = state;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Scoreboard bench for fp_operand_loader with an XOR stand-in for the adder.
module tb_fp_operand_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        load;
  logic        clear;
  logic [31:0] dataR;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] result;
  logic        result_valid;
  logic [1:0]  stage;
  logic [1:0]  entry_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
  } expT;

  expT expQ[$];

  fp_operand_loader #(.DATA_W(8), .WORD_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .load(load),
    .clear(clear),
    .dataR(dataR),
    .dataA(dataA),
    .dataB(dataB),
    .result(result),
    .result_valid(result_valid),
    .stage(stage),
    .entry_idx(entry_idx)
  );

  assign dataR = dataA ^ dataB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus; idx/stage are checked just before the edge.
  task automatic applyStimulus(input logic [7:0] v, input logic doLoad,
                               input logic doClear, input logic [1:0] expIdx,
                               input logic [1:0] expStage);
    @(negedge clk);
    checkOutput("entry_idx before edge", 32'(entry_idx), 32'(expIdx));
    checkOutput("stage before edge", 32'(stage), 32'(expStage));
    data_in = v;
    load    = doLoad;
    clear   = doClear;
    @(posedge clk);
    #1;
    load  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " stage"}, 32'(stage), 32'd0);
    checkOutput({tag, " entry_idx"}, 32'(entry_idx), 32'd0);
    checkOutput({tag, " dataA"}, dataA, 32'h0);
    checkOutput({tag, " dataB"}, dataB, 32'h0);
    checkOutput({tag, " result"}, result, 32'h0);
    checkOutput({tag, " result_valid"}, 32'(result_valid), 32'd0);
  endtask

  // Monitor: each rising result_valid consumes one scoreboard entry.
  logic prevValid = 1'b0;
  always @(negedge clk) begin
    if (result_valid === 1'b1 && prevValid !== 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected result: got 0x%08h, expected no result", result);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("mon result", result, e.res);
        checkOutput("mon dataA", dataA, e.a);
        checkOutput("mon dataB", dataB, e.b);
        checkOutput("mon stage", 32'(stage), 32'd3);
      end
    end
    prevValid = result_valid;
  end

  initial begin
    logic [7:0] vecs [8];
    rst     = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    data_in = 8'h00;

    // Asynchronous reset observed between edges.
    #3 rst = 1'b1;
    #1 checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back full load; XOR of the operands is the expected sum.
    $display("[TB] full back-to-back load");
    vecs = '{8'h40, 8'h60, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expQ.push_back('{32'h00200000, 32'h40600000, 32'h40400000});
      applyStimulus(vecs[i], 1'b1, 1'b0, 2'(i % 4), (i < 4) ? 2'd0 : 2'd1);
    end
    checkOutput("eval stage", 32'(stage), 32'd2);
    checkOutput("eval valid", 32'(result_valid), 32'd0);
    checkOutput("eval dataA", dataA, 32'h40600000);
    checkOutput("eval dataB", dataB, 32'h40400000);
    @(posedge clk);
    #1;
    checkOutput("done stage", 32'(stage), 32'd3);
    checkOutput("done result", result, 32'h00200000);
    checkOutput("done valid", 32'(result_valid), 32'd1);

    // Restart from DONE: the load is entry 0 of the new A.
    $display("[TB] restart from done");
    applyStimulus(8'h3F, 1'b1, 1'b0, 2'd0, 2'd3);
    checkOutput("restart valid", 32'(result_valid), 32'd0);
    checkOutput("restart stage", 32'(stage), 32'd0);
    checkOutput("restart dataA", dataA, 32'h3F600000);
    checkOutput("restart dataB", dataB, 32'h40400000);
    checkOutput("restart entry_idx", 32'(entry_idx), 32'd1);
    checkOutput("restart result", result, 32'h00200000);

    // Finish A, two entries of B, then clear together with a load.
    $display("[TB] clear priority mid-load");
    applyStimulus(8'h80, 1'b1, 1'b0, 2'd1, 2'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 2'd2, 2'd0);
    applyStimulus(8'h01, 1'b1, 1'b0, 2'd3, 2'd0);
    checkOutput("partial dataA", dataA, 32'h3F800001);
    applyStimulus(8'h11, 1'b1, 1'b0, 2'd0, 2'd1);
    applyStimulus(8'h22, 1'b1, 1'b0, 2'd1, 2'd1);
    checkOutput("partial dataB", dataB, 32'h11220000);
    applyStimulus(8'h55, 1'b1, 1'b1, 2'd2, 2'd1);
    checkAllZero("clear");

    // A load during EVAL must be ignored.
    $display("[TB] load during eval");
    vecs = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expQ.push_back('{32'hFF800000, 32'h3F800000, 32'hC0000000});
      applyStimulus(vecs[i], 1'b1, 1'b0, 2'(i % 4), (i < 4) ? 2'd0 : 2'd1);
    end
    applyStimulus(8'hAA, 1'b1, 1'b0, 2'd0, 2'd2);
    checkOutput("evalload stage", 32'(stage), 32'd3);
    checkOutput("evalload dataA", dataA, 32'h3F800000);
    checkOutput("evalload dataB", dataB, 32'hC0000000);
    checkOutput("evalload result", result, 32'hFF800000);
    checkOutput("evalload valid", 32'(result_valid), 32'd1);

    // Reset in the middle of a new operation.
    $display("[TB] reset mid-operation");
    applyStimulus(8'h12, 1'b1, 1'b0, 2'd0, 2'd3);
    applyStimulus(8'h34, 1'b1, 1'b0, 2'd1, 2'd0);
    checkOutput("preRst dataA", dataA, 32'h12340000);
    #2 rst = 1'b1;
    #1 checkAllZero("midRst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
